mem_if: RTL and testbench

Byte-lane memory adapter between the CPU's 16-bit byte-addressed bus and two 8-bit synchronous BRAM banks: a low bank for even byte addresses and a high bank for odd byte addresses. It converts word and byte reads and writes, including unaligned word accesses, into per-bank addresses, write enables and data. It also reassembles the little-endian 16-bit read word. It sits between the MCU's memory port and the external BRAM primitives.

---
 rtl/mem_if.sv | 78 +++++++
 tb/tb_mem_if.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_if.sv
// mem_if: splits the CPU's 16-bit byte-addressed port into even/odd 8-bit BRAM banks and rebuilds the little-endian read word.
// Latency: bank address/enable/data are combinational; rd_data is valid one clock after addr/byt (BRAM output register).
// Backpressure: none, a new access is accepted every cycle. Optional feature macro: MEM_UNALIGNED_EN (odd-address word accesses).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif

module mem_if (
    input  logic                     rst,
    input  logic                     clk,
    input  logic [`ADDR_WIDTH-1:0]   addr,
    input  logic                     wr,
    input  logic                     byt,
    input  logic [15:0]              wr_data,
    output logic [15:0]              rd_data,
    output logic                     bram_rst,
    output logic                     bram_clk,
    output logic                     wr_lo,
    output logic                     wr_hi,
    output logic [`ADDR_WIDTH-2:0]   addr_lo,
    output logic [`ADDR_WIDTH-2:0]   addr_hi,
    output logic [7:0]               wr_data_lo,
    output logic [7:0]               wr_data_hi,
    input  logic [7:0]               rd_data_lo,
    input  logic [7:0]               rd_data_hi
);
    localparam int AW = `ADDR_WIDTH;
    localparam logic [AW-1:0] ONE_A = 1;

    logic          a0_eff;
    logic [AW-1:0] addr_eff;
    logic [AW-1:0] addr_eff_p1;
    logic          a0_d;
    logic          byt_d;

    // Without unaligned support a word access is treated as if addr[0] were 0.
`ifdef MEM_UNALIGNED_EN
    assign a0_eff = addr[0];
`else
    assign a0_eff = addr[0] & byt;
`endif

    assign addr_eff    = {addr[AW-1:1], a0_eff};
    assign addr_eff_p1 = addr_eff + ONE_A;

    assign bram_rst = rst;
    assign bram_clk = clk;

    // The low bank always holds the even byte of the pair, so an odd start spills into the next row (wrapping at the top).
    assign addr_hi = addr[AW-1:1];
    assign addr_lo = addr_eff_p1[AW-1:1];

    assign wr_lo = wr & (~byt | ~a0_eff);
    assign wr_hi = wr & (~byt | a0_eff);

    assign wr_data_lo = (a0_eff & ~byt) ? wr_data[15:8] : wr_data[7:0];
    assign wr_data_hi = (a0_eff | byt)  ? wr_data[7:0]  : wr_data[15:8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a0_d  <= 1'b0;
            byt_d <= 1'b0;
        end else begin
            a0_d  <= a0_eff;
            byt_d <= byt;
        end
    end

    always_comb begin
        rd_data = {rd_data_hi, rd_data_lo};
        if (byt_d) begin
            rd_data = {8'h00, (a0_d ? rd_data_hi : rd_data_lo)};
        end else if (a0_d) begin
            rd_data = {rd_data_lo, rd_data_hi};
        end
    end

endmodule

// File: tb/tb_mem_if.sv
// Bench for mem_if: two behavioural BRAM banks around the DUT, checked against a flat byte-array memory model.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif

module tb_mem_if;
    localparam int AW = `ADDR_WIDTH;
    localparam logic [AW-1:0] ONE_A = 1;
    localparam logic [AW-1:0] TOP_A = '1;

    logic            rst, clk;
    logic [AW-1:0]   addr;
    logic            wr, byt;
    logic [15:0]     wr_data;
    logic [15:0]     rd_data;
    logic            bram_rst, bram_clk;
    logic            wr_lo, wr_hi;
    logic [AW-2:0]   addr_lo, addr_hi;
    logic [7:0]      wr_data_lo, wr_data_hi;
    logic [7:0]      rd_data_lo, rd_data_hi;

    mem_if dut (
        .rst(rst), .clk(clk), .addr(addr), .wr(wr), .byt(byt), .wr_data(wr_data),
        .rd_data(rd_data), .bram_rst(bram_rst), .bram_clk(bram_clk),
        .wr_lo(wr_lo), .wr_hi(wr_hi), .addr_lo(addr_lo), .addr_hi(addr_hi),
        .wr_data_lo(wr_data_lo), .wr_data_hi(wr_data_hi),
        .rd_data_lo(rd_data_lo), .rd_data_hi(rd_data_hi)
    );

    logic [7:0] lo_mem [0:(1<<(AW-1))-1];
    logic [7:0] hi_mem [0:(1<<(AW-1))-1];
    logic [7:0] mem    [0:(1<<AW)-1];

    // Read-first BRAMs with registered outputs cleared by reset.
    always @(posedge bram_clk or posedge bram_rst) begin
        if (bram_rst) begin
            rd_data_lo <= 8'h00;
            rd_data_hi <= 8'h00;
        end else begin
            rd_data_lo <= lo_mem[addr_lo];
            rd_data_hi <= hi_mem[addr_hi];
            if (wr_lo) lo_mem[addr_lo] <= wr_data_lo;
            if (wr_hi) hi_mem[addr_hi] <= wr_data_hi;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic        pend = 1'b0;
    logic [15:0] exp_rd = 16'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bus cycle: check the previous read, apply the new access, check the bank-side signals, update the model.
    task automatic cyc(input logic [AW-1:0] a, input logic w, input logic b, input logic [15:0] d);
        logic [AW-1:0] ea, lo_b, hi_b;
        logic          touch_lo, touch_hi;
        @(negedge clk);
        if (pend) chk("rd_data", 32'(rd_data), 32'(exp_rd));
        addr = a; wr = w; byt = b; wr_data = d;
        #1;
`ifdef MEM_UNALIGNED_EN
        ea = a;
`else
        ea = b ? a : {a[AW-1:1], 1'b0};
`endif
        // The access covers byte ea (and ea+1 for words); each bank serves whichever of the pair has its parity.
        lo_b = ea[0] ? ea + ONE_A : ea;
        hi_b = ea[0] ? ea : ea + ONE_A;
        touch_lo = !b || (ea[0] == 1'b0);
        touch_hi = !b || (ea[0] == 1'b1);
        chk("addr_lo", 32'(addr_lo), 32'(lo_b[AW-1:1]));
        chk("addr_hi", 32'(addr_hi), 32'(hi_b[AW-1:1]));
        chk("wr_lo", 32'(wr_lo), 32'(w && touch_lo));
        chk("wr_hi", 32'(wr_hi), 32'(w && touch_hi));
        if (w && touch_lo) chk("wr_data_lo", 32'(wr_data_lo), 32'((lo_b == ea) ? d[7:0] : d[15:8]));
        if (w && touch_hi) chk("wr_data_hi", 32'(wr_data_hi), 32'((hi_b == ea) ? d[7:0] : d[15:8]));
        exp_rd = b ? {8'h00, mem[ea]} : {mem[ea + ONE_A], mem[ea]};
        pend = 1'b1;
        if (w) begin
            mem[ea] = d[7:0];
            if (!b) mem[ea + ONE_A] = d[15:8];
        end
    endtask

    task automatic rd_now(input string tag, input logic [15:0] exp);
        @(posedge clk);
        #1;
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        logic [AW-1:0] ra;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
        for (int i = 0; i < (1 << (AW-1)); i++) begin
            lo_mem[i] = 8'h00;
            hi_mem[i] = 8'h00;
        end
        rst = 1'b1; addr = '0; wr = 1'b0; byt = 1'b0; wr_data = 16'h0;
        repeat (2) @(negedge clk);
        chk("reset_rd_data", 32'(rd_data), 32'h0);
        chk("reset_bram_rst", 32'(bram_rst), 32'h1);
        rst = 1'b0;
        #1;
        chk("bram_rst_release", 32'(bram_rst), 32'h0);

        // Aligned word write and read-back.
        cyc(12'h300, 1'b1, 1'b0, 16'hBEEF);
        cyc(12'h300, 1'b0, 1'b0, 16'h0);
        rd_now("rd_beef", 16'hBEEF);
        chk("lo_mem_180", 32'(lo_mem[12'h180]), 32'hEF);
        chk("hi_mem_180", 32'(hi_mem[12'h180]), 32'hBE);

        // Odd byte write touches only the high bank.
        cyc(12'h301, 1'b1, 1'b1, 16'hFF12);
        chk("bw_wr_lo", 32'(wr_lo), 32'h0);
        chk("bw_wr_hi", 32'(wr_hi), 32'h1);
        cyc(12'h301, 1'b0, 1'b1, 16'h0);
        rd_now("rd_byte_301", 16'h0012);
        cyc(12'h300, 1'b0, 1'b1, 16'h0);
        rd_now("rd_byte_300", 16'h00EF);

        // Word write/read starting at an odd address.
        cyc(12'h305, 1'b1, 1'b0, 16'hA55A);
        cyc(12'h305, 1'b0, 1'b0, 16'h0);
        rd_now("rd_a55a", 16'hA55A);
`ifdef MEM_UNALIGNED_EN
        chk("hi_mem_182", 32'(hi_mem[12'h182]), 32'h5A);
        chk("lo_mem_183", 32'(lo_mem[12'h183]), 32'hA5);
`else
        chk("lo_mem_182", 32'(lo_mem[12'h182]), 32'h5A);
        chk("hi_mem_182", 32'(hi_mem[12'h182]), 32'hA5);
`endif

        // Top address: the low bank index wraps to zero for an odd start.
        cyc(TOP_A, 1'b0, 1'b1, 16'h0);
        chk("top_addr_lo", 32'(addr_lo), 32'h0);
        chk("top_addr_hi", 32'(addr_hi), 32'((1 << (AW-1)) - 1));
        cyc(TOP_A, 1'b1, 1'b0, 16'h7788);
        cyc(TOP_A, 1'b0, 1'b0, 16'h0);

        // Read-first: same-cycle write returns old data, next read the new.
        cyc(12'h300, 1'b1, 1'b0, 16'h1234);
        rd_now("rd_old", 16'h12EF);
        cyc(12'h300, 1'b0, 1'b0, 16'h0);
        rd_now("rd_new", 16'h1234);

        // Reset in the middle of a stream after an odd word read.
        cyc(12'h305, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        chk("rd_before_rst", 32'(rd_data), 32'(exp_rd));
        pend = 1'b0;
        wr = 1'b0;
        rst = 1'b1;
        #1;
        chk("rd_in_rst", 32'(rd_data), 32'h0);
        chk("bram_rst_mid", 32'(bram_rst), 32'h1);
        repeat (2) @(negedge clk);
        chk("rd_in_rst_held", 32'(rd_data), 32'h0);
        rst = 1'b0;
        cyc(12'h300, 1'b0, 1'b0, 16'h0);
        rd_now("rd_after_rst", 16'h1234);

        // Random traffic in a small window plus the wrap region.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) ra = TOP_A - AW'($urandom_range(0, 3));
            else ra = AW'(12'h300 + $urandom_range(0, 15));
            cyc(ra, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
        end
        cyc(12'h300, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        chk("rd_final", 32'(rd_data), 32'(exp_rd));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
